load_store_unit: RTL

- Sits between the pipeline memory stage and the word-addressed data memory.
- Data memory interface: 32-bit byte address (word index = bits [9:2]), combinational read, synchronous whole-word write.
- Converts RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) into word accesses:
  - sub-word loads: byte-lane extraction plus sign/zero extension;
  - sub-word stores: two-cycle read-modify-write.
- Detects misaligned and illegal accesses and reports them as faults.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/load_align.sv | 32 +++
 rtl/load_store_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the RV32I load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_funct3_e;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } lsu_state_e;

  localparam logic [3:0] LANE_MASK_B = 4'b0001;
  localparam logic [3:0] LANE_MASK_H = 4'b0011;

  // Byte-enable mask for a sub-word store at the given lane offset.
  function automatic logic [3:0] lane_mask(input logic half, input logic [1:0] offset);
    lane_mask = (half ? LANE_MASK_H : LANE_MASK_B) << offset;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane extraction with sign/zero extension.
module load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            offset,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] shifted;
  logic signed [7:0]     byte_s;
  logic signed [15:0]    half_s;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    byte_s  = signed'(shifted[7:0]);
    half_s  = signed'(shifted[15:0]);
    case (funct3)
      LSU_B:   data = DATA_WIDTH'(byte_s);
      LSU_H:   data = DATA_WIDTH'(half_s);
      LSU_BU:  data = DATA_WIDTH'(shifted[7:0]);
      LSU_HU:  data = DATA_WIDTH'(shifted[15:0]);
      // Legal word loads are aligned, so the shift is a no-op here.
      LSU_W:   data = shifted;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: lane-aligned loads, SW direct write, SB/SH read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_store_data,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_load_data,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_byte_address,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  lsu_state_e            state_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [1:0]            offset_p1;
  logic                  half_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  logic                  accept;
  logic                  illegal;
  logic                  misaligned;
  logic                  fault;
  logic                  sw_write;
  logic [DATA_WIDTH-1:0] load_value;
  logic [DATA_WIDTH-1:0] merged;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] src,
    input logic [3:0]            mask,
    input logic [1:0]            offset
  );
    logic [DATA_WIDTH-1:0] shifted;
    shifted = src << {offset, 3'b000};
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      merge_lanes[8*i +: 8] = mask[i] ? shifted[8*i +: 8] : old_word[8*i +: 8];
    end
  endfunction

  // Stage p0: request decode and memory drive
  assign req_ready  = (state_p1 == IDLE);
  assign accept     = req_valid && req_ready;
  assign illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                      (req_is_store && req_funct3[2]);
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_address[0]) ||
                      ((req_funct3 == LSU_W) && (req_address[1:0] != 2'b00));
  assign fault      = illegal || misaligned;
  assign sw_write   = accept && req_is_store && !fault && (req_funct3 == LSU_W);

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .word   (mem_read_data),
    .offset (req_address[1:0]),
    .funct3 (req_funct3),
    .data   (load_value)
  );

  assign merged = merge_lanes(mem_read_data, data_p1, lane_mask(half_p1, offset_p1), offset_p1);

  always_comb begin
    mem_byte_address = (state_p1 == MERGE) ? addr_p1 : req_address;
    // A reset during MERGE must drop the pending write.
    mem_write_enable = !rst && (sw_write || (state_p1 == MERGE));
    mem_write_data   = '0;
    if (mem_write_enable) begin
      mem_write_data = (state_p1 == MERGE) ? merged : req_store_data;
    end
  end

  // Stage p1: control state and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1       <= IDLE;
      resp_valid     <= 1'b0;
      resp_fault     <= 1'b0;
      resp_load_data <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state_p1)
        IDLE: begin
          if (accept) begin
            if (fault) begin
              resp_valid     <= 1'b1;
              resp_fault     <= 1'b1;
              resp_load_data <= '0;
            end else if (!req_is_store) begin
              resp_valid     <= 1'b1;
              resp_fault     <= 1'b0;
              resp_load_data <= load_value;
            end else if (req_funct3 == LSU_W) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b0;
            end else begin
              state_p1 <= MERGE;
            end
          end
        end
        MERGE: begin
          state_p1   <= IDLE;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
        end
        default: state_p1 <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1   <= {req_address[ADDR_WIDTH-1:2], 2'b00};
      offset_p1 <= req_address[1:0];
      half_p1   <= req_funct3[0];
      data_p1   <= req_store_data;
    end
  end

endmodule
